divider_32: RTL and testbench
=============================

DIVIDER_32 -- requirements
Module: divider_32

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits; only 32 is required to be verified.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1: request valid; dividend/divisor sampled when start && in_ready.
REQ-005 SHALL have port in_ready, output, 1: block accepts a new request; high only in IDLE.
REQ-006 SHALL have port dividend, input, WIDTH: numerator.
REQ-007 SHALL have port divisor, input, WIDTH: denominator.
REQ-008 SHALL have port quotient, output, WIDTH: result quotient, valid while out_valid.
REQ-009 SHALL have port remainder, output, WIDTH: result remainder, valid while out_valid.
REQ-010 SHALL have port div_by_zero, output, 1: result came from divisor == 0; valid while out_valid.
REQ-011 SHALL have port out_valid, output, 1: result available.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts result when out_valid && out_ready.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; IDLE->BUSY on start && in_ready && divisor != 0; IDLE->DONE on start && in_ready && divisor == 0; BUSY->DONE after exactly WIDTH iterations; DONE->IDLE on out_valid && out_ready.
REQ-014 SHALL perform restoring division, one quotient bit per BUSY cycle, MSB first; partial remainder held WIDTH+1 bits wide to absorb the trial-subtract borrow.
REQ-015 SHALL assert out_valid exactly WIDTH+1 cycles after the accepting cycle for divisor != 0 (33 for WIDTH=32), and the cycle after acceptance for divisor == 0.
REQ-016 SHALL hold quotient, remainder, div_by_zero and out_valid stable in DONE until handshake completes; out_valid deasserts the cycle after out_valid && out_ready.
REQ-017 SHALL ignore start and input changes while not in IDLE; no request queueing.
REQ-018 SHALL, for divisor == 0, output quotient = all ones, remainder = dividend, div_by_zero = 1; otherwise div_by_zero = 0.
REQ-019 SHALL satisfy dividend == quotient*divisor + remainder with remainder < divisor (unsigned mode) for every nonzero divisor.
REQ-020 SHALL NOT allow in_ready to be high in the same cycle as out_valid (no DONE->accept bypass).

Reset
REQ-021 SHALL, on reset high at a clock edge, enter IDLE from any state, abandoning any in-flight operation with no result produced.
REQ-022 SHALL drive in reset: in_ready = 1 the cycle after reset releases; out_valid = 0, quotient = 0, remainder = 0, div_by_zero = 0.
REQ-023 SHALL give reset priority over start and out_ready in the same cycle.

Configuration
REQ-024 SHALL compile signed support only when macro DIVIDER_32_SIGNED_EN is defined.
REQ-025 With DIVIDER_32_SIGNED_EN: operands two's complement; magnitudes divided; quotient truncates toward zero; remainder takes sign of dividend; sign fix-up applied on BUSY->DONE edge with no added latency.
REQ-026 With DIVIDER_32_SIGNED_EN: most-negative / -1 SHALL yield quotient = most-negative, remainder = 0, div_by_zero = 0; divide by zero as REQ-018.
REQ-027 Without DIVIDER_32_SIGNED_EN: operands and results unsigned only; no sign logic present.

Structure
REQ-028 SHALL place FSM state enum (IDLE, BUSY, DONE) and default WIDTH constant in shared package divider_pkg.
REQ-029 SHALL use one combinational sub-module divider_step (shift in next dividend bit, trial subtract, produce quotient bit and next partial remainder); iteration counter and FSM stay in divider_32.

Verification
REQ-030 Unsigned 100 / 7, out_ready held high -> out_valid after 33 cycles, quotient 14, remainder 2, div_by_zero 0.
REQ-031 0xFFFFFFFF / 1 and 5 / 0xFFFFFFFF -> quotient 0xFFFFFFFF rem 0; quotient 0 rem 5.
REQ-032 0x12345678 / 0 -> out_valid next cycle, quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero 1.
REQ-033 out_ready low 10 cycles in DONE, start pulsed meanwhile -> outputs stable, in_ready 0, start ignored; single transfer when out_ready rises.
REQ-034 reset asserted at BUSY iteration 15 -> IDLE, out_valid never asserts; next request 9 / 3 -> quotient 3 rem 0.
REQ-035 With DIVIDER_32_SIGNED_EN: -7 / 2 -> quotient -3 rem -1; 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000 rem 0.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the divider_32 block: FSM state encoding and the default operand width.
package divider_pkg;

    localparam int DIVIDER_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract, keep or restore.
module divider_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DIVIDER_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             quotient_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // rem_in < divisor, so the shifted value stays below 2*divisor and the top bit of trial is the borrow.
    assign shifted      = {rem_in, dividend_bit};
    assign trial        = shifted - {2'b00, divisor};
    assign quotient_bit = ~trial[WIDTH+1];
    assign rem_out      = quotient_bit ? trial[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/divider_32.sv
// Multi-cycle restoring divider with valid/ready handshakes on both sides.
// Signed (two's complement) operation is compiled in only when DIVIDER_32_SIGNED_EN is defined.
module divider_32
    import divider_pkg::*;
#(
    parameter int WIDTH = DIVIDER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   part_rem;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] div_reg;
    logic             accept;
    logic             divisor_zero;
    logic             last_iter;
    logic [WIDTH:0]   step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] op_dividend;
    logic [WIDTH-1:0] op_divisor;
    logic [WIDTH-1:0] final_quo;
    logic [WIDTH-1:0] final_rem;

    assign accept       = start && in_ready;
    assign divisor_zero = (divisor == '0);
    assign last_iter    = (count == CNT_W'(WIDTH - 1));

    divider_step #(.WIDTH(WIDTH)) u_step (
        .rem_in       (part_rem),
        .dividend_bit (work[WIDTH-1]),
        .divisor      (div_reg),
        .rem_out      (step_rem),
        .quotient_bit (step_bit)
    );

`ifdef DIVIDER_32_SIGNED_EN
    logic neg_quo;
    logic neg_rem;

    // Divide magnitudes; the most-negative value maps to itself, which is its correct unsigned magnitude.
    assign op_dividend = dividend[WIDTH-1] ? -dividend : dividend;
    assign op_divisor  = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign final_quo   = neg_quo ? -{work[WIDTH-2:0], step_bit} : {work[WIDTH-2:0], step_bit};
    assign final_rem   = neg_rem ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else if (accept) begin
            neg_quo <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem <= dividend[WIDTH-1];
        end
    end
`else
    assign op_dividend = dividend;
    assign op_divisor  = divisor;
    assign final_quo   = {work[WIDTH-2:0], step_bit};
    assign final_rem   = step_rem[WIDTH-1:0];
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (start) state_next = divisor_zero ? DONE : BUSY;
            end
            BUSY: begin
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            part_rem    <= '0;
            work        <= '0;
            div_reg     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        count    <= '0;
                        part_rem <= '0;
                        work     <= op_dividend;
                        div_reg  <= op_divisor;
                        if (divisor_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // work shifts dividend bits out at the top while quotient bits enter at the bottom.
                    count    <= count + CNT_W'(1);
                    part_rem <= step_rem;
                    work     <= {work[WIDTH-2:0], step_bit};
                    if (last_iter) begin
                        quotient    <= final_quo;
                        remainder   <= final_rem;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_32.sv
// Directed-vector bench for divider_32; signed vectors are added when DIVIDER_32_SIGNED_EN is defined.
module tb_divider_32;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        out_valid;
    logic        out_ready;

    int n_compared;
    int n_mismatched;

    divider_32 #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a request for one cycle, then scramble the inputs (they must be ignored while busy).
    task automatic launch(input string name, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0000;
    endtask

    // Called one cycle after acceptance; counts cycles until out_valid with a bounded budget.
    task automatic wait_valid(input string name, input int exp_lat);
        int lat;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_out(input string name, input logic [31:0] eq, input logic [31:0] er,
                             input logic ez);
        check({name, " quotient"}, quotient, eq);
        check({name, " remainder"}, remainder, er);
        check({name, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
        check({name, " in_ready in DONE"}, 32'(in_ready), 32'd0);
    endtask

    // Full transaction with out_ready held high: result is consumed on the edge after it appears.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] eq, input logic [31:0] er,
                          input logic ez);
        out_ready = 1'b1;
        launch(name, a, b);
        wait_valid(name, exp_lat);
        check_out(name, eq, er, ez);
        @(negedge clk);
        check({name, " out_valid drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int seen_valid;
        n_compared   = 0;
        n_mismatched = 0;
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset div_by_zero", 32'(div_by_zero), 32'd0);

        run_op("100/7", 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);
        run_op("max/1", 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op("x/0", 32'h1234_5678, 32'd0, 1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        run_op("1000000/1000", 32'd1000000, 32'd1000, 33, 32'd1000, 32'd0, 1'b0);
        run_op("3/10", 32'd3, 32'd10, 33, 32'd0, 32'd3, 1'b0);
`ifndef DIVIDER_32_SIGNED_EN
        run_op("5/max", 32'd5, 32'hFFFF_FFFF, 33, 32'd0, 32'd5, 1'b0);
        run_op("deadbeef/16", 32'hDEAD_BEEF, 32'h10, 33, 32'h0DEA_DBEE, 32'hF, 1'b0);
`endif

        // Backpressure: result must hold while out_ready is low, and start must be ignored.
        out_ready = 1'b0;
        launch("bp 200/9", 32'd200, 32'd9);
        wait_valid("bp 200/9", 33);
        for (int i = 0; i < 10; i++) begin
            start    = i[0];
            dividend = 32'd77;
            divisor  = 32'd5;
            @(negedge clk);
            check("bp hold out_valid", 32'(out_valid), 32'd1);
            check("bp hold quotient", quotient, 32'd22);
            check("bp hold remainder", remainder, 32'd2);
            check("bp hold in_ready", 32'(in_ready), 32'd0);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp transfer out_valid", 32'(out_valid), 32'd0);
        check("bp back to idle", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("bp no queued request", 32'(in_ready), 32'd1);

        // Reset in the middle of an operation abandons it without producing a result.
        launch("abort 1000/3", 32'd1000, 32'd3);
        repeat (14) @(negedge clk);
        check("abort busy in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort quotient", quotient, 32'd0);
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        check("abort out_valid cycles", 32'(seen_valid), 32'd0);
        run_op("9/3", 32'd9, 32'd3, 33, 32'd3, 32'd0, 1'b0);

`ifdef DIVIDER_32_SIGNED_EN
        run_op("-7/2", 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op("7/-2", 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run_op("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, 1'b0);
        run_op("-5/0", 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
